// File: rtl/radix_4_div_pkg.sv
// Shared definitions for the radix-4 divider: quotient digit bit positions
// (common with the sign coder) and the on-the-fly converter state encoding.
package radix_4_div_pkg;

   localparam int QUOT_NEG_2 = 0;
   localparam int QUOT_NEG_1 = 1;
   localparam int QUOT_ZERO  = 2;
   localparam int QUOT_POS_1 = 3;
   localparam int QUOT_POS_2 = 4;

   typedef enum logic [1:0] {
      OTFC_IDLE,
      OTFC_RUN,
      OTFC_DONE
   } otfc_state_e;

endpackage

// File: rtl/radix_4_otfc_sel.sv
// Combinational next-value selection for the on-the-fly converter.
// Produces Q/QM after appending one radix-4 digit; non-one-hot digits act as 0.
module radix_4_otfc_sel
   import radix_4_div_pkg::*;
#(
   parameter int WIDTH = 64
) (
   input  logic [WIDTH-1:0] q,
   input  logic [WIDTH-1:0] qm,
   input  logic [4:0]       quot,
   output logic [WIDTH-1:0] q_nxt,
   output logic [WIDTH-1:0] qm_nxt
);

   always_comb begin
      q_nxt  = {q[WIDTH-3:0], 2'b00};
      qm_nxt = {qm[WIDTH-3:0], 2'b11};
      if ($onehot(quot)) begin
         if (quot[QUOT_POS_2]) begin
            q_nxt  = {q[WIDTH-3:0], 2'b10};
            qm_nxt = {q[WIDTH-3:0], 2'b01};
         end else if (quot[QUOT_POS_1]) begin
            q_nxt  = {q[WIDTH-3:0], 2'b01};
            qm_nxt = {q[WIDTH-3:0], 2'b00};
         end else if (quot[QUOT_NEG_1]) begin
            // Negative digits borrow from QM, so no carry chain is ever needed
            q_nxt  = {qm[WIDTH-3:0], 2'b11};
            qm_nxt = {qm[WIDTH-3:0], 2'b10};
         end else if (quot[QUOT_NEG_2]) begin
            q_nxt  = {qm[WIDTH-3:0], 2'b10};
            qm_nxt = {qm[WIDTH-3:0], 2'b01};
         end
      end
   end

endmodule

// File: rtl/radix_4_otfc.sv
// Radix-4 on-the-fly quotient converter: accumulates WIDTH/2 signed digits into Q and Q-1.
// Optional macro RADIX_4_OTFC_DIGIT_CHECK_EN enables the sticky illegal-digit flag err_o.
module radix_4_otfc
   import radix_4_div_pkg::*;
#(
   parameter int WIDTH = 64,
   parameter int CNT_W = $clog2(WIDTH/2+1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             quot_vld_i,
   input  logic [4:0]       quot_i,
   output logic             busy_o,
   output logic             res_vld_o,
   input  logic             res_rdy_i,
   output logic [WIDTH-1:0] quot_o,
   output logic [WIDTH-1:0] quot_m1_o,
   output logic             err_o
);

   localparam int LAST_DIGIT = WIDTH/2 - 1;

   otfc_state_e      state;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] qm;
   logic [WIDTH-1:0] q_nxt;
   logic [WIDTH-1:0] qm_nxt;
   logic [CNT_W-1:0] cnt;
   logic             res_vld;

   radix_4_otfc_sel #(
      .WIDTH (WIDTH)
   ) u_sel (
      .q      (q),
      .qm     (qm),
      .quot   (quot_i),
      .q_nxt  (q_nxt),
      .qm_nxt (qm_nxt)
   );

`ifdef RADIX_4_OTFC_DIGIT_CHECK_EN
   logic err;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err <= 1'b0;
      end else if (start_i) begin
         err <= 1'b0;
      end else if (state == OTFC_RUN && quot_vld_i && !$onehot(quot_i)) begin
         err <= 1'b1;
      end
   end

   assign err_o = err;
`else
   assign err_o = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= OTFC_IDLE;
         q       <= '0;
         qm      <= '0;
         cnt     <= '0;
         res_vld <= 1'b0;
      end else if (start_i) begin
         // A start also completes any pending DONE handshake implicitly
         state   <= OTFC_RUN;
         q       <= '0;
         qm      <= '1;
         cnt     <= '0;
         res_vld <= 1'b0;
      end else begin
         case (state)
            OTFC_RUN: begin
               if (quot_vld_i) begin
                  q   <= q_nxt;
                  qm  <= qm_nxt;
                  cnt <= cnt + CNT_W'(1);
                  if (cnt == CNT_W'(LAST_DIGIT)) begin
                     state   <= OTFC_DONE;
                     res_vld <= 1'b1;
                  end
               end
            end
            OTFC_DONE: begin
               if (res_rdy_i) begin
                  state   <= OTFC_IDLE;
                  res_vld <= 1'b0;
               end
            end
            default: begin
               state <= OTFC_IDLE;
            end
         endcase
      end
   end

   assign busy_o    = (state == OTFC_RUN);
   assign res_vld_o = res_vld;
   assign quot_o    = q;
   assign quot_m1_o = qm;

endmodule

// File: tb/tb_radix_4_otfc.sv
// Self-checking bench for radix_4_otfc (WIDTH=8): directed cases plus randomized
// conversions checked against an integer-arithmetic quotient model.
module tb_radix_4_otfc;

   localparam int WIDTH = 8;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             start_i = 1'b0;
   logic             quot_vld_i = 1'b0;
   logic [4:0]       quot_i = 5'b00100;
   logic             busy_o;
   logic             res_vld_o;
   logic             res_rdy_i = 1'b0;
   logic [WIDTH-1:0] quot_o;
   logic [WIDTH-1:0] quot_m1_o;
   logic             err_o;

   int n_tests = 0;
   int n_fail  = 0;

   longint m_val;
   int     m_digits;
   logic   m_err;

   radix_4_otfc #(
      .WIDTH (WIDTH)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start_i    (start_i),
      .quot_vld_i (quot_vld_i),
      .quot_i     (quot_i),
      .busy_o     (busy_o),
      .res_vld_o  (res_vld_o),
      .res_rdy_i  (res_rdy_i),
      .quot_o     (quot_o),
      .quot_m1_o  (quot_m1_o),
      .err_o      (err_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   function automatic int dval(input logic [4:0] code);
      if ($countones(code) != 1) return 0;
      for (int i = 0; i < 5; i++) if (code[i]) return i - 2;
      return 0;
   endfunction

   function automatic logic [WIDTH-1:0] exp_q();
      longint v = m_val;
      return v[WIDTH-1:0];
   endfunction

   function automatic logic [WIDTH-1:0] exp_qm();
      longint v = m_val - 1;
      return v[WIDTH-1:0];
   endfunction

   function automatic logic exp_err();
`ifdef RADIX_4_OTFC_DIGIT_CHECK_EN
      return m_err;
`else
      return 1'b0;
`endif
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start();
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      m_val = 0; m_digits = 0; m_err = 1'b0;
      check("start_busy", busy_o, 1'b1);
      check("start_vld", res_vld_o, 1'b0);
      check("start_q", quot_o, 0);
      check("start_qm", quot_m1_o, {WIDTH{1'b1}});
      check("start_err", err_o, 1'b0);
   endtask

   task automatic send_digit(input logic [4:0] code, input int gap);
      for (int g = 0; g < gap; g++) begin
         quot_vld_i = 1'b0;
         quot_i = 5'($urandom);
         step();
         check("gap_q", quot_o, exp_q());
      end
      quot_vld_i = 1'b1;
      quot_i = code;
      step();
      quot_vld_i = 1'b0;
      m_val = m_val * 4 + dval(code);
      m_digits++;
      if ($countones(code) != 1) m_err = 1'b1;
      check("dig_q", quot_o, exp_q());
      check("dig_qm", quot_m1_o, exp_qm());
      check("dig_err", err_o, exp_err());
      if (m_digits == WIDTH/2) begin
         check("done_vld", res_vld_o, 1'b1);
         check("done_busy", busy_o, 1'b0);
      end else begin
         check("run_vld", res_vld_o, 1'b0);
         check("run_busy", busy_o, 1'b1);
      end
   endtask

   task automatic take_result(input int wait_cyc);
      res_rdy_i = 1'b0;
      for (int k = 0; k < wait_cyc; k++) begin
         quot_vld_i = 1'b1;
         quot_i = 5'b1 << $urandom_range(0, 4);
         step();
         check("hold_vld", res_vld_o, 1'b1);
         check("hold_q", quot_o, exp_q());
         check("hold_qm", quot_m1_o, exp_qm());
      end
      quot_vld_i = 1'b0;
      res_rdy_i = 1'b1;
      step();
      res_rdy_i = 1'b0;
      check("hs_vld", res_vld_o, 1'b0);
      check("hs_busy", busy_o, 1'b0);
      check("hs_q", quot_o, exp_q());
      // Digits offered in IDLE must not disturb the held result
      quot_vld_i = 1'b1;
      quot_i = 5'b10000;
      step();
      quot_vld_i = 1'b0;
      check("idle_q", quot_o, exp_q());
      check("idle_busy", busy_o, 1'b0);
   endtask

   initial begin
      m_val = 0; m_digits = 0; m_err = 1'b0;
      step();
      check("rst_busy", busy_o, 1'b0);
      check("rst_vld", res_vld_o, 1'b0);
      check("rst_q", quot_o, 0);
      check("rst_qm", quot_m1_o, 0);
      check("rst_err", err_o, 1'b0);
      rst = 1'b0;
      step();

      // Case 1: +1,+2,0,-1
      do_start();
      send_digit(5'b01000, 0); send_digit(5'b10000, 0);
      send_digit(5'b00100, 0); send_digit(5'b00010, 0);
      check("c1_q", quot_o, 8'h5F);
      check("c1_qm", quot_m1_o, 8'h5E);
      take_result(0);

      // Case 2: -2 x4
      do_start();
      for (int i = 0; i < 4; i++) send_digit(5'b00001, 0);
      check("c2_q", quot_o, 8'h56);
      check("c2_qm", quot_m1_o, 8'h55);
      take_result(1);

      // Case 3: case 1 with gaps and delayed ready
      do_start();
      send_digit(5'b01000, 0); send_digit(5'b10000, 3);
      send_digit(5'b00100, 3); send_digit(5'b00010, 3);
      check("c3_q", quot_o, 8'h5F);
      take_result(5);

      // Case 4: abort after two digits, then +1 x4
      do_start();
      send_digit(5'b10000, 0); send_digit(5'b10000, 0);
      do_start();
      for (int i = 0; i < 4; i++) send_digit(5'b01000, 0);
      check("c4_q", quot_o, 8'h55);
      take_result(0);

      // Case 5: illegal digits in place of 0
      do_start();
      send_digit(5'b01000, 0); send_digit(5'b10000, 0);
      send_digit(5'b00000, 0); send_digit(5'b00010, 0);
      check("c5a_q", quot_o, 8'h5F);
      check("c5a_err", err_o, exp_err());
      take_result(0);
      check("c5a_err_held", err_o, exp_err());
      do_start();
      send_digit(5'b01000, 0); send_digit(5'b10000, 0);
      send_digit(5'b11000, 0); send_digit(5'b00010, 0);
      check("c5b_q", quot_o, 8'h5F);
      check("c5b_err", err_o, exp_err());

      // start together with the DONE handshake starts a new run
      res_rdy_i = 1'b1;
      do_start();
      res_rdy_i = 1'b0;

      // Case 6: asynchronous reset mid-RUN
      send_digit(5'b10000, 0); send_digit(5'b01000, 0);
      #2 rst = 1'b1;
      #1;
      check("c6_busy", busy_o, 1'b0);
      check("c6_vld", res_vld_o, 1'b0);
      check("c6_q", quot_o, 0);
      check("c6_qm", quot_m1_o, 0);
      check("c6_err", err_o, 1'b0);
      #3 rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         quot_vld_i = 1'b1;
         quot_i = 5'b10000;
         step();
         check("c6_ign_q", quot_o, 0);
         check("c6_ign_busy", busy_o, 1'b0);
         check("c6_ign_vld", res_vld_o, 1'b0);
      end
      quot_vld_i = 1'b0;

      // Randomized conversions
      for (int r = 0; r < 30; r++) begin
         do_start();
         if ($urandom_range(0, 4) == 0) begin
            for (int i = 0; i < $urandom_range(1, 3); i++)
               send_digit(5'b1 << $urandom_range(0, 4), $urandom_range(0, 1));
            do_start();
         end
         for (int i = 0; i < WIDTH/2; i++) begin
            logic [4:0] code;
            if ($urandom_range(0, 9) == 0) begin
               code = 5'($urandom);
               if ($countones(code) == 1) code = 5'b00000;
            end else begin
               code = 5'b1 << $urandom_range(0, 4);
            end
            send_digit(code, $urandom_range(0, 2));
         end
         take_result($urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
